// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: FSM state encoding, bubble word, PC increment and the word-alignment
//          mask, which ID-stage branch-target logic also uses.
// Ports:   none (package)
package fetch_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int          PC_INC    = 4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus
// Purpose: groups the fetch request and the memory response signals.
// Ports:   imem_req/imem_addr (fetch side out), imem_ready/imem_rdata (memory side out)
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register (IR, PC+4, valid)
// Purpose: holds the instruction handed to ID; flush inserts a bubble and
//          overrides load.
// Ports:   clk, rst (async active-high), i_load, i_flush, i_ir, i_pc4 -> o_ir, o_pc4, o_valid
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_ir,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_ir,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_ir;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= NOP_WORD;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_ir    <= NOP_WORD;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_ir    <= i_ir;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_ir    = r_ir;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with IF/ID register
// Purpose: PC register, one-outstanding-request fetch FSM, one-entry stall
//          buffer and drain address latch; handles ID stall and branch redirect.
// Ports:   clk, reset (async active-high), stall, branch_taken, branch_target,
//          imem (fetch_unit_if.master), IR, IR_valid, ID_PC4
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD,
    parameter int          PC_INC   = fetch_pkg::PC_INC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    fetch_unit_if.master       imem,
    output logic [31:0]        IR,
    output logic               IR_valid,
    output logic [31:0]        ID_PC4
);
    import fetch_pkg::*;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_drain_addr;
    logic [31:0]  r_buf_ir;
    logic [31:0]  r_buf_pc4;
    logic         r_buf_valid;

    logic [31:0]  w_pc_seq;
    logic [31:0]  w_target;
    logic         w_load;
    logic         w_flush;
    logic [31:0]  w_load_ir;
    logic [31:0]  w_load_pc4;

    assign w_pc_seq = r_pc + 32'(PC_INC);
    assign w_target = align_word(branch_target);

    assign imem.imem_req  = (r_state == FETCH) || (r_state == DRAIN);
    // While draining, the old request must stay on the bus even though PC
    // already points at the redirect target.
    assign imem.imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

    always_comb begin
        w_flush    = branch_taken;
        w_load     = 1'b0;
        w_load_ir  = imem.imem_rdata;
        w_load_pc4 = w_pc_seq;
        case (r_state)
            FETCH: w_load = imem.imem_ready && !stall;
            HOLD: begin
                w_load     = !stall && r_buf_valid;
                w_load_ir  = r_buf_ir;
                w_load_pc4 = r_buf_pc4;
            end
            default: w_load = 1'b0;
        endcase
    end

    if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_ir    (w_load_ir),
        .i_pc4   (w_load_pc4),
        .o_ir    (IR),
        .o_pc4   (ID_PC4),
        .o_valid (IR_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= START;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_buf_ir     <= NOP_WORD;
            r_buf_pc4    <= 32'h0;
            r_buf_valid  <= 1'b0;
        end else begin
            case (r_state)
                START: begin
                    if (branch_taken) r_pc <= w_target;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        r_pc <= w_target;
                        // A request still in flight must complete before the
                        // target can be fetched; its word is thrown away.
                        if (!imem.imem_ready) begin
                            r_drain_addr <= r_pc;
                            r_state      <= DRAIN;
                        end
                    end else if (imem.imem_ready) begin
                        r_pc <= w_pc_seq;
                        if (stall) begin
                            r_buf_ir    <= imem.imem_rdata;
                            r_buf_pc4   <= w_pc_seq;
                            r_buf_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        r_pc        <= w_target;
                        r_buf_valid <= 1'b0;
                        r_state     <= FETCH;
                    end else if (!stall) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (branch_taken) r_pc <= w_target;
                    if (imem.imem_ready) r_state <= FETCH;
                end
                default: r_state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        tb_ready;
    logic [31:0] IR;
    logic        IR_valid;
    logic [31:0] ID_PC4;

    logic [31:0] mem [0:63];

    fetch_unit_if bus();

    assign bus.imem_ready = tb_ready;
    assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .IR            (IR),
        .IR_valid      (IR_valid),
        .ID_PC4        (ID_PC4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] t;
        logic        r;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_ir;
        logic        e_v;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic b, input logic [31:0] t, input logic r,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_ir, input logic e_v, input logic [31:0] e_pc4);
        vec_t v;
        v.s = s; v.b = b; v.t = t; v.r = r;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ir = e_ir; v.e_v = e_v; v.e_pc4 = e_pc4;
        vecs.push_back(v);
    endfunction

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pre_req;
        logic [31:0] pre_addr;
        logic [31:0] pre_ir;
        logic [31:0] pre_pc4;
        logic        s_applied;
        logic        r_applied;
        logic [31:0] last_pc4;
        int          popped;
        exp_t        e;

        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 2);
        mem[0] = 32'hE082_1003;
        mem[1] = 32'hE591_2004;
        mem[2] = 32'hE3A0_1005;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; tb_ready = 1'b1;

        // stall branch target      rdy  req addr           IR            v  PC4
        add(0, 0, 32'h0,        1,   0, 32'h0000_0000, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0000, 32'hE082_1003, 1, 32'h4);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0004, 32'hE591_2004, 1, 32'h8);
        add(1, 0, 32'h0,        1,   1, 32'h0000_0008, 32'hE591_2004, 1, 32'h8);
        add(1, 0, 32'h0,        1,   0, 32'h0000_000C, 32'hE591_2004, 1, 32'h8);
        add(0, 0, 32'h0,        1,   0, 32'h0000_000C, 32'hE3A0_1005, 1, 32'hC);
        add(0, 1, 32'h42,       1,   1, 32'h0000_000C, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0040, 32'hA000_0040, 1, 32'h44);
        add(0, 1, 32'h80,       0,   1, 32'h0000_0044, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        0,   1, 32'h0000_0044, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        0,   1, 32'h0000_0044, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0044, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0080, 32'hA000_0080, 1, 32'h84);
        add(1, 1, 32'h10,       1,   1, 32'h0000_0084, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0010, 32'hA000_0010, 1, 32'h14);
        add(1, 0, 32'h0,        1,   1, 32'h0000_0014, 32'hA000_0010, 1, 32'h14);
        add(1, 1, 32'h4,        1,   0, 32'h0000_0018, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0004, 32'hE591_2004, 1, 32'h8);
        add(0, 1, 32'h8,        1,   1, 32'h0000_0008, 32'h0000_0000, 0, 32'h0);
        add(1, 0, 32'h0,        1,   1, 32'h0000_0008, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   0, 32'h0000_000C, 32'hE3A0_1005, 1, 32'hC);
        add(0, 1, 32'hFFFF_FFFF,1,   1, 32'h0000_000C, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'hFFFF_FFFC, 32'hA000_00FC, 1, 32'h0);
        add(0, 0, 32'h0,        1,   1, 32'h0000_0000, 32'hE082_1003, 1, 32'h4);

        repeat (3) @(negedge clk);
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_ir", IR, 32'h0);
        check("rst_valid", {31'h0, IR_valid}, 32'h0);
        check("rst_pc4", ID_PC4, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].s; branch_taken = vecs[i].b; branch_target = vecs[i].t; tb_ready = vecs[i].r;
            #1;
            check($sformatf("v%0d_req", i), {31'h0, bus.imem_req}, {31'h0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
            @(negedge clk);
            check($sformatf("v%0d_ir", i), IR, vecs[i].e_ir);
            check($sformatf("v%0d_valid", i), {31'h0, IR_valid}, {31'h0, vecs[i].e_v});
            check($sformatf("v%0d_pc4", i), ID_PC4, vecs[i].e_pc4);
        end

        // Reset while in HOLD: immediate, buffered word must not survive.
        stall = 1'b1; branch_taken = 1'b0; tb_ready = 1'b1;
        @(negedge clk);
        check("hold_req", {31'h0, bus.imem_req}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("arst_ir", IR, 32'h0);
        check("arst_valid", {31'h0, IR_valid}, 32'h0);
        check("arst_req", {31'h0, bus.imem_req}, 32'h0);
        check("arst_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        #1;
        check("rel_c1_req", {31'h0, bus.imem_req}, 32'h0);
        @(negedge clk);
        check("rel_c2_req", {31'h0, bus.imem_req}, 32'h1);
        check("rel_c2_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        check("rel_first_ir", IR, 32'hE082_1003);
        check("rel_first_pc4", ID_PC4, 32'h4);

        // Scoreboard run: random stalls and wait states, no branches. The IR
        // stream must be the memory contents in address order.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 64; k++) begin
            e.ir  = mem[k];
            e.pc4 = 32'(k * 4 + 4);
            sb.push_back(e);
        end
        last_pc4 = 32'h0;
        popped   = 0;
        for (int c = 0; c < 80; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            tb_ready = ($urandom_range(0, 3) != 0);
            #1;
            pre_req   = bus.imem_req;
            pre_addr  = bus.imem_addr;
            pre_ir    = IR;
            pre_pc4   = ID_PC4;
            s_applied = stall;
            r_applied = tb_ready;
            @(negedge clk);
            if (s_applied) begin
                check($sformatf("sb%0d_stall_ir", c), IR, pre_ir);
                check($sformatf("sb%0d_stall_pc4", c), ID_PC4, pre_pc4);
            end
            if (pre_req && !r_applied) begin
                check($sformatf("sb%0d_addr_hold", c), bus.imem_addr, pre_addr);
            end
            if (IR_valid && ID_PC4 != last_pc4) begin
                if (sb.size() == 0) begin
                    check($sformatf("sb%0d_empty", c), 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("sb%0d_ir", c), IR, e.ir);
                    check($sformatf("sb%0d_pc4", c), ID_PC4, e.pc4);
                    popped++;
                end
                last_pc4 = ID_PC4;
            end
        end
        check("sb_progress", {31'h0, popped >= 10}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
